// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Handshake: the master raises dm_req with dm_we/dm_addr/dm_wstrb/dm_wdata and holds all of
// them stable until the slave pulses dm_ack. The access completes in that cycle, and load data
// is valid on dm_rdata only while dm_ack is high. dm_ack is ignored while dm_req is low.
interface mem_access_unit_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
      input  dm_ack, dm_rdata
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
      output dm_ack, dm_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the miniRV pipeline: issues loads/stores over a req/ack bus, stalls upstream
// while an access is in flight, and produces the write-back triple for MEM/WB.
module mem_access_unit (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ex_valid,
   input  logic                     ex_rf_we,
   input  logic [4:0]               ex_wR,
   input  logic [31:0]              ex_alu_res,
   input  logic [31:0]              ex_rs2_data,
   input  logic                     ex_mem_rd,
   input  logic                     ex_mem_wr,
   input  logic [2:0]               ex_funct3,
   input  logic [31:0]              ex_pc,
   mem_access_unit_if.master        dm,
   output logic                     stall_o,
   output logic                     misalign_o,
   output logic                     rf_we_o,
   output logic [4:0]               wR_o,
   output logic [31:0]              wD_o,
   output logic [31:0]              debug_pc_o,
   output logic                     debug_have_inst_o,
   output logic                     dbg_state_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

   state_e      state_q;
   logic        dm_we_q;
   logic [31:0] dm_addr_q;
   logic [3:0]  dm_wstrb_q;
   logic [31:0] dm_wdata_q;
   logic        rf_we_q;
   logic [4:0]  wr_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic [31:0] pc_q;

   logic        mem_op;
   logic        misaligned;
   logic [1:0]  off;
   logic [3:0]  dm_wstrb_d;
   logic [31:0] dm_wdata_d;
   logic [31:0] rdata_shifted;
   logic [15:0] load_half;
   logic [31:0] load_data;
   logic        stall;

   assign mem_op = ex_valid & (ex_mem_rd | ex_mem_wr);
   assign off    = ex_alu_res[1:0];

   // Size is taken from funct3[1:0] only; the sign bit never affects alignment or strobes.
   always_comb begin
      misaligned = 1'b0;
      dm_wstrb_d = 4'b1111;
      dm_wdata_d = ex_rs2_data;
      case (ex_funct3[1:0])
         2'b00: begin
            dm_wstrb_d = 4'b0001 << off;
            dm_wdata_d = {4{ex_rs2_data[7:0]}};
         end
         2'b01: begin
            misaligned = off[0];
            dm_wstrb_d = off[1] ? 4'b1100 : 4'b0011;
            dm_wdata_d = {2{ex_rs2_data[15:0]}};
         end
         default: misaligned = (off != 2'b00);
      endcase
      if (!ex_mem_wr) dm_wstrb_d = 4'b0000;
   end

   assign rdata_shifted = dm.dm_rdata >> {off_q, 3'b000};
   assign load_half     = off_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

   always_comb begin
      load_data = dm.dm_rdata;
      case (funct3_q[1:0])
         2'b00:   load_data = funct3_q[2] ? {24'b0, rdata_shifted[7:0]}
                                          : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'b01:   load_data = funct3_q[2] ? {16'b0, load_half}
                                          : {{16{load_half[15]}}, load_half};
         default: load_data = dm.dm_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dm_we_q    <= 1'b0;
         dm_addr_q  <= 32'b0;
         dm_wstrb_q <= 4'b0;
         dm_wdata_q <= 32'b0;
         rf_we_q    <= 1'b0;
         wr_q       <= 5'b0;
         funct3_q   <= 3'b0;
         off_q      <= 2'b0;
         pc_q       <= 32'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_op && !misaligned) begin
                  state_q    <= BUSY;
                  dm_we_q    <= ex_mem_wr;
                  dm_addr_q  <= {ex_alu_res[31:2], 2'b00};
                  dm_wstrb_q <= dm_wstrb_d;
                  dm_wdata_q <= dm_wdata_d;
                  rf_we_q    <= ex_rf_we;
                  wr_q       <= ex_wR;
                  funct3_q   <= ex_funct3;
                  off_q      <= off;
                  pc_q       <= ex_pc;
               end
            end
            BUSY: begin
               if (dm.dm_ack) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dm.dm_req   = (state_q == BUSY);
   assign dm.dm_we    = dm_we_q;
   assign dm.dm_addr  = dm_addr_q;
   assign dm.dm_wstrb = dm_wstrb_q;
   assign dm.dm_wdata = dm_wdata_q;
   assign dbg_state_o = (state_q == BUSY);

   always_comb begin
      stall             = 1'b0;
      misalign_o        = 1'b0;
      rf_we_o           = 1'b0;
      wR_o              = ex_wR;
      wD_o              = ex_alu_res;
      debug_pc_o        = ex_pc;
      debug_have_inst_o = 1'b0;
      if (state_q == IDLE) begin
         if (!mem_op) begin
            rf_we_o           = ex_valid & ex_rf_we;
            debug_have_inst_o = ex_valid;
         end else if (misaligned) begin
            misalign_o        = 1'b1;
            debug_have_inst_o = 1'b1;
         end else begin
            stall = 1'b1;
         end
      end else begin
         debug_pc_o = pc_q;
         wR_o       = wr_q;
         if (dm.dm_ack) begin
            debug_have_inst_o = 1'b1;
            rf_we_o           = rf_we_q & ~dm_we_q;
            wD_o              = load_data;
         end else begin
            stall = 1'b1;
         end
      end
   end

   // A pending mem_op on the EX/MEM inputs must not hold the pipeline frozen during reset.
   assign stall_o = stall & rst_n;

endmodule
